wb_ctrl: RTL and testbench
==========================

Name: wb_ctrl

Overview:
- Writeback sequencer for the register-file write port.
- Accepts one writeback request per cycle from the execute stage and drives the 2-bit writeback-source select (00 ALU, 01 load data, 10 sign-extended immediate, 11 link PC+8), write enable and destination register.
- Loads stall the pipeline until memory returns data, with a timeout error path and a stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 255, cycles spent in LOAD_WAIT before the load is abandoned (must be >=1).
CNT_W, 32, width of the stall-cycle counter.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous active-low reset.
req_valid  input  1  execute stage presents a writeback request.
req_kind  input  2  source select: 00 ALU, 01 load, 10 sign-extend, 11 link.
req_dest  input  5  destination register number.
req_ready  output  1  combinational; high only in IDLE.
mem_rvalid  input  1  load data valid on the data-memory read port this cycle.
wb_sel  output  2  registered select to the writeback mux.
reg_we  output  1  registered register-file write enable.
reg_waddr  output  5  registered register-file write address.
stall  output  1  combinational; high in LOAD_WAIT.
mem_err  output  1  sticky load-timeout flag.
err_clr  input  1  clears mem_err.
stall_cycles  output  CNT_W  saturating count of cycles with stall=1.

Behaviour:
- Reset (reset_n=0, asynchronous) forces these values:
  - state=IDLE; wb_sel=00; reg_we=0; reg_waddr=0.
  - mem_err=0; stall_cycles=0; internal timeout counter=0; held load dest=0.
- Reset asserted mid-load abandons the load. No write is issued afterwards.
- Handshake: a request is accepted when req_valid && req_ready. Requests while req_ready=0 are not accepted, and the requester holds them.
- IDLE, accepted non-load (kind 00/10/11):
  - Next cycle: wb_sel=req_kind, reg_waddr=req_dest, reg_we=(req_dest!=0).
  - State stays IDLE, so back-to-back requests are written on consecutive cycles.
  - Latency is 1 cycle.
- IDLE, accepted load (kind 01):
  - Latch dest and clear the timeout counter.
  - Next cycle: state=LOAD_WAIT and reg_we=0.
- IDLE with no accepted request: next cycle reg_we=0. wb_sel and reg_waddr hold their last values.
- mem_rvalid in IDLE is ignored.
- LOAD_WAIT:
  - stall=1, req_ready=0, reg_we=0. The timeout counter increments each cycle.
  - On mem_rvalid: next cycle wb_sel=01, reg_waddr=held dest, reg_we=(held dest!=0), state=IDLE.
  - A new request can be accepted in that write cycle.
- Timeout:
  - Condition: in LOAD_WAIT, counter==MEM_TIMEOUT-1 and mem_rvalid=0.
  - Next cycle: state=IDLE, mem_err=1, reg_we=0. No write is issued.
  - If mem_rvalid and the timeout condition occur in the same cycle, mem_rvalid wins: normal write, no error.
- mem_err:
  - Set by a timeout; cleared by err_clr on the next edge.
  - If set and clear occur in the same cycle, set wins.
- stall_cycles increments on every edge where stall=1 and saturates at all-ones (no wrap).
- Destination 0: the request is accepted and sequenced normally, but reg_we stays 0.
- reg_we is never high for more than one cycle per accepted request.

Test Plan:
- Reset, then ALU request (kind 00, dest 5) accepted at cycle T -> at T+1 wb_sel=00, reg_we=1, reg_waddr=5; at T+2 reg_we=0.
- Back-to-back requests (kind 10 dest 7, kind 11 dest 31) on consecutive cycles -> writes on consecutive cycles with matching sel/addr, req_ready constantly 1.
- Load (kind 01) to dest 9, mem_rvalid 3 cycles after entering LOAD_WAIT; ALU request held during the wait:
  - stall=1 and req_ready=0 for 4 cycles; stall_cycles=4.
  - Then wb_sel=01, reg_we=1, reg_waddr=9.
  - The held ALU request is accepted in that write cycle.
- Load with MEM_TIMEOUT=4 and no mem_rvalid:
  - After 4 LOAD_WAIT cycles, state returns to IDLE, mem_err=1, no write.
  - err_clr pulse -> mem_err=0.
  - Repeat with mem_rvalid on the 4th wait cycle -> write occurs, mem_err stays 0.
- Request with dest 0 (kind 00), then a load to dest 0 -> reg_we never asserts; the load still stalls until mem_rvalid.
- Assert reset_n=0 mid-LOAD_WAIT, then mem_rvalid after release -> all outputs zero during reset, no write afterwards, state IDLE.

Source files
------------

// File: rtl/wb_ctrl.sv
// Writeback sequencer: turns execute-stage requests into register-file write
// strobes, stalling on loads until memory answers or a timeout abandons them.
module wb_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [1:0]       req_kind,
  input  logic [4:0]       req_dest,
  output logic             req_ready,
  input  logic             mem_rvalid,
  output logic [1:0]       wb_sel,
  output logic             reg_we,
  output logic [4:0]       reg_waddr,
  output logic             stall,
  output logic             mem_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             state_dbg
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // while req_ready is low the requester must hold req_kind/req_dest stable.

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_LOAD_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] KIND_LOAD = 2'b01;
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic       accept;
  logic       is_load;
  logic       tmo_hit;
  logic [TW-1:0] tmo_cnt;
  logic [4:0] hold_dest;
  logic [1:0] wb_sel_nxt;
  logic       reg_we_nxt;
  logic [4:0] reg_waddr_nxt;

  assign req_ready = (state == S_IDLE);
  assign stall     = (state == S_LOAD_WAIT);
  assign state_dbg = state;
  assign accept    = req_valid && req_ready;
  assign is_load   = (req_kind == KIND_LOAD);
  // mem_rvalid takes priority over an expiring timeout in the same cycle.
  assign tmo_hit   = stall && !mem_rvalid && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && is_load) state_nxt = S_LOAD_WAIT;
      end
      S_LOAD_WAIT: begin
        if (mem_rvalid || tmo_hit) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered writeback outputs; sel/addr hold when idle.
  always_comb begin
    wb_sel_nxt    = wb_sel;
    reg_waddr_nxt = reg_waddr;
    reg_we_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && !is_load) begin
          wb_sel_nxt    = req_kind;
          reg_waddr_nxt = req_dest;
          reg_we_nxt    = (req_dest != 5'd0);
        end
      end
      S_LOAD_WAIT: begin
        if (mem_rvalid) begin
          wb_sel_nxt    = KIND_LOAD;
          reg_waddr_nxt = hold_dest;
          reg_we_nxt    = (hold_dest != 5'd0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_sel    <= 2'b00;
      reg_we    <= 1'b0;
      reg_waddr <= 5'd0;
    end else begin
      wb_sel    <= wb_sel_nxt;
      reg_we    <= reg_we_nxt;
      reg_waddr <= reg_waddr_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_dest <= 5'd0;
      tmo_cnt   <= '0;
    end else if (accept && is_load) begin
      hold_dest <= req_dest;
      tmo_cnt   <= '0;
    end else if (stall) begin
      tmo_cnt   <= tmo_cnt + TW'(1);
    end
  end

  // A timeout in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     mem_err <= 1'b0;
    else if (tmo_hit) mem_err <= 1'b1;
    else if (err_clr) mem_err <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != {CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// Self-checking bench for wb_ctrl: directed scenarios with a write scoreboard
// and a narrow-counter instance for stall_cycles saturation.
module tb_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [1:0]  req_kind;
  logic [4:0]  req_dest;
  logic        req_ready;
  logic        mem_rvalid;
  logic [1:0]  wb_sel;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic        stall;
  logic        mem_err;
  logic        err_clr;
  logic [31:0] stall_cycles;
  logic        state_dbg;

  logic        s_req_ready, s_reg_we, s_stall, s_mem_err, s_state_dbg;
  logic [1:0]  s_wb_sel;
  logic [4:0]  s_reg_waddr;
  logic [2:0]  s_stall_cycles;

  int errors = 0;
  int checks = 0;
  int exp_stall = 0;
  logic [6:0] exp_q[$];

  wb_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_kind(req_kind),
    .req_dest(req_dest), .req_ready(req_ready), .mem_rvalid(mem_rvalid),
    .wb_sel(wb_sel), .reg_we(reg_we), .reg_waddr(reg_waddr), .stall(stall),
    .mem_err(mem_err), .err_clr(err_clr), .stall_cycles(stall_cycles),
    .state_dbg(state_dbg)
  );

  wb_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) u_sat (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_kind(req_kind),
    .req_dest(req_dest), .req_ready(s_req_ready), .mem_rvalid(mem_rvalid),
    .wb_sel(s_wb_sel), .reg_we(s_reg_we), .reg_waddr(s_reg_waddr), .stall(s_stall),
    .mem_err(s_mem_err), .err_clr(err_clr), .stall_cycles(s_stall_cycles),
    .state_dbg(s_state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (reset_n && reg_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write: got sel=%0d addr=%0d, expected no write", wb_sel, reg_waddr);
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        if ({wb_sel, reg_waddr} !== e) begin
          errors++;
          $display("FAIL sb_write: got sel=%0d addr=%0d, expected sel=%0d addr=%0d",
                   wb_sel, reg_waddr, e[6:5], e[4:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] kind, input logic [4:0] dest);
    req_valid = 1'b1;
    req_kind  = kind;
    req_dest  = dest;
  endtask

  task automatic check_stall_counts(input string name);
    int sat;
    sat = (exp_stall > 7) ? 7 : exp_stall;
    chk({name, "_stall_cycles"}, stall_cycles, exp_stall);
    chk({name, "_stall_cycles_sat"}, {29'd0, s_stall_cycles}, sat);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_kind = 2'b00; req_dest = 5'd0;
    mem_rvalid = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    chk("rst_wb_sel", wb_sel, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_waddr", reg_waddr, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_stall", stall, 0);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive_req(2'b00, 5'd5);
    chk("alu_ready", req_ready, 1);
    exp_q.push_back({2'b00, 5'd5});
    tick();
    req_valid = 1'b0;
    chk("alu_we", reg_we, 1);
    chk("alu_sel", wb_sel, 2'b00);
    chk("alu_addr", reg_waddr, 5);
    tick();
    chk("alu_we_drop", reg_we, 0);
    chk("alu_addr_hold", reg_waddr, 5);
  endtask

  task automatic test_back_to_back();
    drive_req(2'b10, 5'd7);
    chk("b2b_ready0", req_ready, 1);
    exp_q.push_back({2'b10, 5'd7});
    tick();
    chk("b2b_we0", reg_we, 1);
    chk("b2b_sel0", wb_sel, 2'b10);
    chk("b2b_addr0", reg_waddr, 7);
    drive_req(2'b11, 5'd31);
    chk("b2b_ready1", req_ready, 1);
    exp_q.push_back({2'b11, 5'd31});
    tick();
    req_valid = 1'b0;
    chk("b2b_we1", reg_we, 1);
    chk("b2b_sel1", wb_sel, 2'b11);
    chk("b2b_addr1", reg_waddr, 31);
    tick();
    chk("b2b_we_drop", reg_we, 0);
  endtask

  task automatic test_load();
    drive_req(2'b01, 5'd9);
    exp_q.push_back({2'b01, 5'd9});
    tick();
    chk("ld_we_accept", reg_we, 0);
    drive_req(2'b00, 5'd3);
    for (int i = 0; i < 4; i++) begin
      chk("ld_stall", stall, 1);
      chk("ld_ready", req_ready, 0);
      chk("ld_we_wait", reg_we, 0);
      mem_rvalid = (i == 3);
      exp_stall++;
      tick();
    end
    mem_rvalid = 1'b0;
    chk("ld_we", reg_we, 1);
    chk("ld_sel", wb_sel, 2'b01);
    chk("ld_addr", reg_waddr, 9);
    chk("ld_ready_after", req_ready, 1);
    chk("ld_mem_err", mem_err, 0);
    check_stall_counts("ld");
    exp_q.push_back({2'b00, 5'd3});
    tick();
    req_valid = 1'b0;
    chk("ld_held_we", reg_we, 1);
    chk("ld_held_sel", wb_sel, 2'b00);
    chk("ld_held_addr", reg_waddr, 3);
    tick();
    chk("ld_held_we_drop", reg_we, 0);
  endtask

  task automatic test_timeout();
    drive_req(2'b01, 5'd12);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("tmo_stall", stall, 1);
      err_clr = (i == 3);
      exp_stall++;
      tick();
    end
    err_clr = 1'b0;
    chk("tmo_state", state_dbg, 0);
    chk("tmo_mem_err", mem_err, 1);
    chk("tmo_we", reg_we, 0);
    chk("tmo_stall_off", stall, 0);
    check_stall_counts("tmo");
    tick();
    chk("tmo_err_sticky", mem_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_err_clr", mem_err, 0);
    drive_req(2'b01, 5'd12);
    exp_q.push_back({2'b01, 5'd12});
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = (i == 3);
      exp_stall++;
      tick();
    end
    mem_rvalid = 1'b0;
    chk("tmo_edge_we", reg_we, 1);
    chk("tmo_edge_addr", reg_waddr, 12);
    chk("tmo_edge_err", mem_err, 0);
    check_stall_counts("tmo_edge");
    tick();
  endtask

  task automatic test_dest0();
    drive_req(2'b00, 5'd0);
    tick();
    chk("d0_alu_we", reg_we, 0);
    chk("d0_alu_addr", reg_waddr, 0);
    drive_req(2'b01, 5'd0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("d0_ld_stall", stall, 1);
      mem_rvalid = (i == 1);
      exp_stall++;
      tick();
    end
    mem_rvalid = 1'b0;
    chk("d0_ld_we", reg_we, 0);
    chk("d0_ld_sel", wb_sel, 2'b01);
    chk("d0_ld_state", state_dbg, 0);
    check_stall_counts("d0");
  endtask

  task automatic test_rvalid_idle();
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("idle_rvalid_we", reg_we, 0);
    chk("idle_rvalid_state", state_dbg, 0);
  endtask

  task automatic test_reset_mid_load();
    int k;
    k = $urandom_range(1, 3);
    drive_req(2'b01, 5'd20);
    tick();
    req_valid = 1'b0;
    repeat (k) tick();
    chk("rml_in_wait", stall, 1);
    reset_n = 1'b0;
    #2;
    exp_stall = 0;
    chk("rml_wb_sel", wb_sel, 0);
    chk("rml_reg_we", reg_we, 0);
    chk("rml_reg_waddr", reg_waddr, 0);
    chk("rml_mem_err", mem_err, 0);
    chk("rml_state", state_dbg, 0);
    check_stall_counts("rml");
    tick();
    reset_n = 1'b1;
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    chk("rml_after_we", reg_we, 0);
    chk("rml_after_state", state_dbg, 0);
    tick();
    chk("rml_after_we2", reg_we, 0);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_load();
    test_timeout();
    test_dest0();
    test_rvalid_idle();
    test_reset_mid_load();
    repeat (2) tick();
    chk("sb_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
